operand_fetch: RTL

Operand-fetch and writeback sequencer sitting directly upstream of `register_file`. It accepts decoded source/destination register requests and writeback data, then drives the register file's level-sensitive request strobes with a setup-then-strobe protocol. It captures read data after a fixed latency and presents operands to the execute stage over a valid/ready handshake. It is the only block that drives `register_file` request, address and write-data inputs.

---
 rtl/operand_fetch_pkg.sv | 19 +
 rtl/operand_fetch_if.sv | 60 ++++++
 rtl/operand_fetch_rf_write_port.sv | 56 +++++
 rtl/operand_fetch.sv | 135 +++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch / writeback sequencer.
package operand_fetch_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // Register x0 is hardwired to zero: never read, never written.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        RSETUP,
        RSTROBE,
        HOLD,
        WSETUP,
        WSTROBE
    } of_state_e;

endpackage : operand_fetch_pkg

// File: rtl/operand_fetch_if.sv
// Decode, writeback, register-file and execute-side signals of operand_fetch.
interface operand_fetch_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);

    logic              dec_valid_i;
    logic              dec_ready_o;
    logic [ADDR_W-1:0] dec_rs1_i;
    logic [ADDR_W-1:0] dec_rs2_i;
    logic              dec_use_rs1_i;
    logic              dec_use_rs2_i;

    logic              wb_valid_i;
    logic              wb_ready_o;
    logic [ADDR_W-1:0] wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              rf_req_ra_o;
    logic              rf_req_rb_o;
    logic              rf_req_w_o;
    logic [ADDR_W-1:0] rf_raddr_a_o;
    logic [ADDR_W-1:0] rf_raddr_b_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic [DATA_W-1:0] rf_rdata_a_i;
    logic [DATA_W-1:0] rf_rdata_b_i;

    logic              ex_valid_o;
    logic              ex_ready_i;
    logic [DATA_W-1:0] ex_op_a_o;
    logic [DATA_W-1:0] ex_op_b_o;

    // Sequencer side.
    modport master (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
        output dec_ready_o,
        input  wb_valid_i, wb_addr_i, wb_data_i,
        output wb_ready_o,
        output rf_req_ra_o, rf_req_rb_o, rf_req_w_o,
        output rf_raddr_a_o, rf_raddr_b_o, rf_waddr_o, rf_wdata_o,
        input  rf_rdata_a_i, rf_rdata_b_i,
        output ex_valid_o, ex_op_a_o, ex_op_b_o,
        input  ex_ready_i
    );

    // Environment side (decode, writeback source, register file, execute).
    modport slave (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
        input  dec_ready_o,
        output wb_valid_i, wb_addr_i, wb_data_i,
        input  wb_ready_o,
        input  rf_req_ra_o, rf_req_rb_o, rf_req_w_o,
        input  rf_raddr_a_o, rf_raddr_b_o, rf_waddr_o, rf_wdata_o,
        output rf_rdata_a_i, rf_rdata_b_i,
        input  ex_valid_o, ex_op_a_o, ex_op_b_o,
        output ex_ready_i
    );

endinterface : operand_fetch_if

// File: rtl/operand_fetch_rf_write_port.sv
// Register-file write sequencer: one setup cycle, then a single-cycle strobe.
module rf_write_port #(
    parameter int unsigned ADDR_W = operand_fetch_pkg::ADDR_W,
    parameter int unsigned DATA_W = operand_fetch_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              req_w,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              done
);

    import operand_fetch_pkg::*;

    of_state_e state;
    of_state_e state_n;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: IDLE -> WSETUP -> WSTROBE -> IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = WSETUP;
            WSETUP:  state_n = WSTROBE;
            WSTROBE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address/data latched on start and held until the next write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waddr <= '0;
            wdata <= '0;
        end else if (start && (state == IDLE)) begin
            waddr <= addr;
            wdata <= data;
        end
    end

    assign req_w = (state == WSTROBE);
    assign done  = (state == WSTROBE);

endmodule : rf_write_port

// File: rtl/operand_fetch.sv
// Operand-fetch and writeback sequencer in front of register_file.
module operand_fetch #(
    parameter int unsigned ADDR_W = operand_fetch_pkg::ADDR_W,
    parameter int unsigned DATA_W = operand_fetch_pkg::DATA_W,
    parameter int unsigned RD_LAT = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    operand_fetch_if.master bus
);

    import operand_fetch_pkg::*;

    localparam int unsigned CNT_W = unsigned'($clog2(RD_LAT + 1));

    of_state_e         state;
    of_state_e         state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              capture;
    logic              wb_fire;
    logic              dec_fire;
    logic              wr_start;
    logic              wr_done;
    logic              act_a_n;
    logic              act_b_n;
    logic              act_a_q;
    logic              act_b_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;

    // Accept decisions; writeback has priority over decode in IDLE.
    assign wb_fire  = (state == IDLE) && !rst_i && bus.wb_valid_i;
    assign dec_fire = (state == IDLE) && !rst_i && !bus.wb_valid_i && bus.dec_valid_i;
    assign wr_start = wb_fire && (bus.wb_addr_i != ADDR_W'(REG_ZERO));
    assign act_a_n  = bus.dec_use_rs1_i && (bus.dec_rs1_i != ADDR_W'(REG_ZERO));
    assign act_b_n  = bus.dec_use_rs2_i && (bus.dec_rs2_i != ADDR_W'(REG_ZERO));

    assign bus.wb_ready_o  = (state == IDLE) && !rst_i && bus.wb_valid_i;
    assign bus.dec_ready_o = (state == IDLE) && !rst_i && !bus.wb_valid_i;

    // State and read-latency counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic and read-capture strobe.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (wb_fire) begin
                    state_n = wr_start ? WSETUP : IDLE;
                end else if (dec_fire) begin
                    state_n = (act_a_n || act_b_n) ? RSETUP : HOLD;
                end
            end
            RSETUP: begin
                state_n = RSTROBE;
                cnt_n   = CNT_W'(RD_LAT - 1);
            end
            RSTROBE: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD:    if (bus.ex_ready_i) state_n = IDLE;
            WSETUP:  state_n = WSTROBE;
            WSTROBE: if (wr_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Read request latch and operand capture; inactive ports read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            act_a_q <= 1'b0;
            act_b_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            if (dec_fire) begin
                rs1_q   <= bus.dec_rs1_i;
                rs2_q   <= bus.dec_rs2_i;
                act_a_q <= act_a_n;
                act_b_q <= act_b_n;
                op_a_q  <= '0;
                op_b_q  <= '0;
            end
            if (capture) begin
                op_a_q <= act_a_q ? bus.rf_rdata_a_i : '0;
                op_b_q <= act_b_q ? bus.rf_rdata_b_i : '0;
            end
        end
    end

    assign bus.rf_req_ra_o  = (state == RSTROBE) && act_a_q;
    assign bus.rf_req_rb_o  = (state == RSTROBE) && act_b_q;
    assign bus.rf_raddr_a_o = rs1_q;
    assign bus.rf_raddr_b_o = rs2_q;
    assign bus.ex_valid_o   = (state == HOLD);
    assign bus.ex_op_a_o    = op_a_q;
    assign bus.ex_op_b_o    = op_b_q;

    rf_write_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (wr_start),
        .addr  (bus.wb_addr_i),
        .data  (bus.wb_data_i),
        .req_w (bus.rf_req_w_o),
        .waddr (bus.rf_waddr_o),
        .wdata (bus.rf_wdata_o),
        .done  (wr_done)
    );

endmodule : operand_fetch
